rc4_ksa_engine: RTL and testbench

Parametrised RC4 key-scheduling engine that owns the S-box memory port during initialisation and scrambling. Optionally fills S[k]=k, then runs the KSA swap loop j = (j + S[i] + key[i mod KEY_BYTES]) mod N. It sits between the top-level control FSM and the single-port S-box RAM, ahead of the PRGA/decrypt stage. Runs are launched with a start/done handshake and can be repeated with new keys without reset.

---
 rtl/rc4_ksa_engine.sv | 206 ++++++++++++++++++++
 tb/tb_rc4_ksa_engine.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine.
// Owns the single-port S-box RAM while it optionally fills S[k]=k and then
// runs the KSA swap loop j = j + S[i] + key[i mod KEY_BYTES]. Each KSA
// iteration reads S[i], reads S[j], then writes S[j]=S[i] and S[i]=S[j].
// All RAM-side outputs are registered, so each state computes the outputs
// the next state needs.
module rc4_ksa_engine #(
    parameter int ADDR_W    = 8,
    parameter int KEY_BYTES = 3,
    parameter int RD_LAT    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        do_init,
    input  logic [ADDR_W*KEY_BYTES-1:0] key,
    output logic                        busy,
    output logic                        done,
    output logic [ADDR_W-1:0]           addr,
    output logic [ADDR_W-1:0]           wrdata,
    output logic                        wren,
    input  logic [ADDR_W-1:0]           rddata
);

    localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam int WAIT_W = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

    localparam logic [ADDR_W-1:0] IDX_LAST  = '1;
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
    // WAIT states last RD_LAT-1 cycles: load RD_LAT-2 and count down to zero.
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((RD_LAT >= 2) ? (RD_LAT - 2) : 0);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FILL,
        ST_RD_I,
        ST_WAIT_I,
        ST_CAP_I,
        ST_RD_J,
        ST_WAIT_J,
        ST_CAP_J,
        ST_WR_J,
        ST_WR_I
    } state_t;

    state_t                        state_q;
    logic [ADDR_W*KEY_BYTES-1:0]   key_q;
    logic [ADDR_W-1:0]             i_q;
    logic [ADDR_W-1:0]             j_q;
    logic [ADDR_W-1:0]             si_q;
    logic [ADDR_W-1:0]             sj_q;
    logic [KIDX_W-1:0]             kidx_q;
    logic [WAIT_W-1:0]             wait_q;
    logic [ADDR_W-1:0]             addr_q;
    logic [ADDR_W-1:0]             wrdata_q;
    logic                          wren_q;
    logic                          busy_q;
    logic                          done_q;

    // Key element 0 lives in the MSBs of the latched key.
    logic [ADDR_W-1:0] key_elem [KEY_BYTES];

    for (genvar gi = 0; gi < KEY_BYTES; gi++) begin : g_key_elem
        assign key_elem[gi] = key_q[(KEY_BYTES-1-gi)*ADDR_W +: ADDR_W];
    end

    logic [ADDR_W-1:0] key_sel;
    logic [ADDR_W-1:0] j_d;

    // Next j for the CAP_I cycle; natural ADDR_W wrap gives the mod N.
    always_comb begin
        key_sel = key_elem[kidx_q];
        j_d     = j_q + rddata + key_sel;
    end

    // Control FSM with registered RAM-side outputs and handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            key_q    <= '0;
            i_q      <= '0;
            j_q      <= '0;
            si_q     <= '0;
            sj_q     <= '0;
            kidx_q   <= '0;
            wait_q   <= '0;
            addr_q   <= '0;
            wrdata_q <= '0;
            wren_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    wren_q <= 1'b0;
                    if (start) begin
                        key_q  <= key;
                        i_q    <= '0;
                        j_q    <= '0;
                        kidx_q <= '0;
                        busy_q <= 1'b1;
                        addr_q <= '0;
                        if (do_init) begin
                            wrdata_q <= '0;
                            wren_q   <= 1'b1;
                            state_q  <= ST_FILL;
                        end else begin
                            state_q  <= ST_RD_I;
                        end
                    end
                end
                // i doubles as the fill index k; it is back at 0 for the KSA.
                ST_FILL: begin
                    if (i_q == IDX_LAST) begin
                        i_q     <= '0;
                        addr_q  <= '0;
                        wren_q  <= 1'b0;
                        state_q <= ST_RD_I;
                    end else begin
                        i_q      <= i_q + 1'b1;
                        addr_q   <= i_q + 1'b1;
                        wrdata_q <= i_q + 1'b1;
                    end
                end
                ST_RD_I: begin
                    wren_q <= 1'b0;
                    if (RD_LAT == 1) begin
                        state_q <= ST_CAP_I;
                    end else begin
                        wait_q  <= WAIT_INIT;
                        state_q <= ST_WAIT_I;
                    end
                end
                ST_WAIT_I: begin
                    if (wait_q == '0) begin
                        state_q <= ST_CAP_I;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                ST_CAP_I: begin
                    si_q    <= rddata;
                    j_q     <= j_d;
                    addr_q  <= j_d;
                    state_q <= ST_RD_J;
                end
                ST_RD_J: begin
                    if (RD_LAT == 1) begin
                        state_q <= ST_CAP_J;
                    end else begin
                        wait_q  <= WAIT_INIT;
                        state_q <= ST_WAIT_J;
                    end
                end
                ST_WAIT_J: begin
                    if (wait_q == '0) begin
                        state_q <= ST_CAP_J;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                ST_CAP_J: begin
                    sj_q     <= rddata;
                    addr_q   <= j_q;
                    wrdata_q <= si_q;
                    wren_q   <= 1'b1;
                    state_q  <= ST_WR_J;
                end
                // When i==j both reads saw the same value, so both writes agree.
                ST_WR_J: begin
                    addr_q   <= i_q;
                    wrdata_q <= sj_q;
                    wren_q   <= 1'b1;
                    state_q  <= ST_WR_I;
                end
                ST_WR_I: begin
                    wren_q <= 1'b0;
                    if (i_q == IDX_LAST) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        addr_q  <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        i_q     <= i_q + 1'b1;
                        addr_q  <= i_q + 1'b1;
                        kidx_q  <= (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
                        state_q <= ST_RD_I;
                    end
                end
                default: begin
                    wren_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign addr   = addr_q;
    assign wrdata = wrdata_q;
    assign wren   = wren_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Testbench for rc4_ksa_engine: default instance plus a KEY_BYTES=5,
// RD_LAT=3 instance, each with a behavioural single-port RAM.
module tb_rc4_ksa_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- default instance ----------------
    logic        start = 1'b0;
    logic        do_init = 1'b0;
    logic [23:0] key = '0;
    logic        busy, done, wren;
    logic [7:0]  addr, wrdata, rddata;

    rc4_ksa_engine u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .do_init(do_init), .key(key),
        .busy(busy), .done(done), .addr(addr), .wrdata(wrdata), .wren(wren),
        .rddata(rddata)
    );

    logic [7:0] mem [256];
    logic [7:0] pipe [2];
    always @(posedge clk) begin
        if (wren) mem[addr] <= wrdata;
        pipe[0] <= mem[addr];
        pipe[1] <= pipe[0];
    end
    assign rddata = pipe[1];

    // ---------------- KEY_BYTES=5, RD_LAT=3 instance ----------------
    logic        start5 = 1'b0;
    logic        do_init5 = 1'b0;
    logic [39:0] key5 = '0;
    logic        busy5, done5, wren5;
    logic [7:0]  addr5, wrdata5, rddata5;

    rc4_ksa_engine #(.ADDR_W(8), .KEY_BYTES(5), .RD_LAT(3)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .do_init(do_init5), .key(key5),
        .busy(busy5), .done(done5), .addr(addr5), .wrdata(wrdata5), .wren(wren5),
        .rddata(rddata5)
    );

    logic [7:0] mem5 [256];
    logic [7:0] pipe5 [3];
    always @(posedge clk) begin
        if (wren5) mem5[addr5] <= wrdata5;
        pipe5[0] <= mem5[addr5];
        pipe5[1] <= pipe5[0];
        pipe5[2] <= pipe5[1];
    end
    assign rddata5 = pipe5[2];

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    logic [7:0] model_s [256];
    logic [7:0] log_addr [4096];
    logic [7:0] log_wd   [4096];
    logic       log_wren [4096];

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Software RC4 KSA on model_s; key element e is at bits [(kb-1-e)*8 +: 8].
    task automatic model_run(input logic [39:0] k, input int kb, input bit init);
        int         j;
        logic [7:0] t;
        logic [7:0] kv;
        j = 0;
        if (init) for (int x = 0; x < 256; x++) model_s[x] = 8'(x);
        for (int i = 0; i < 256; i++) begin
            kv = k[(kb-1-(i % kb))*8 +: 8];
            j = (j + int'(model_s[i]) + int'(kv)) % 256;
            t = model_s[i];
            model_s[i] = model_s[j];
            model_s[j] = t;
        end
    endtask

    task automatic check_s(input string nm);
        int m;
        m = 0;
        for (int x = 0; x < 256; x++) if (mem[x] !== model_s[x]) m++;
        check(nm, m, 0);
    endtask

    // Called at a negedge; start is seen at the next posedge. Returns at the
    // negedge of cycle 1.
    task automatic launch(input logic [23:0] k, input bit init);
        start = 1'b1;
        key = k;
        do_init = init;
        @(negedge clk);
        start = 1'b0;
        check("done_low_cycle1", done, 0);
    endtask

    // Starts in cycle 1, returns at the negedge of the done cycle.
    task automatic wait_done(output int cyc, output int writes);
        int busy_err;
        bit found;
        cyc = 1; writes = 0; busy_err = 0; found = 0;
        while (!found && cyc < 5000) begin
            if (cyc < 4096) begin
                log_addr[cyc] = addr;
                log_wd[cyc]   = wrdata;
                log_wren[cyc] = wren;
            end
            if (wren) writes++;
            if (done) begin
                found = 1;
                if (busy) busy_err++;
            end else begin
                if (!busy) busy_err++;
                @(negedge clk);
                cyc++;
            end
        end
        check("done_seen", found, 1);
        check("busy_window", busy_err, 0);
    endtask

    typedef struct {
        logic [23:0] key;
        bit          init;
        int          exp_done;
        int          exp_writes;
    } vec_t;

    vec_t vecs [3];

    initial begin
        int cyc, wr, cnt, fill_err;

        vecs[0] = '{key: 24'h000000, init: 1'b1, exp_done: 2305, exp_writes: 768};
        vecs[1] = '{key: 24'h010203, init: 1'b1, exp_done: 2305, exp_writes: 768};
        vecs[2] = '{key: 24'h4B6579, init: 1'b0, exp_done: 2049, exp_writes: 512};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_addr", addr, 0);
        check("rst_wrdata", wrdata, 0);
        check("rst_wren", wren, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven runs; model state carries across do_init=0 runs
        for (int v = 0; v < 3; v++) begin
            model_run({16'h0, vecs[v].key}, 3, vecs[v].init);
            launch(vecs[v].key, vecs[v].init);
            wait_done(cyc, wr);
            $display("run key=%h init=%0d done_cycle=%0d writes=%0d",
                     vecs[v].key, vecs[v].init, cyc, wr);
            check("done_cycle", cyc, vecs[v].exp_done);
            check("write_cycles", wr, vecs[v].exp_writes);
            check_s("sbox");
            if (vecs[v].key == 24'h010203) begin
                fill_err = 0;
                for (int c = 1; c <= 256; c++)
                    if (!log_wren[c] || log_addr[c] != 8'(c-1) || log_wd[c] != 8'(c-1))
                        fill_err++;
                check("fill_seq", fill_err, 0);
                check("rd_i0", {log_wren[257], log_addr[257]}, {1'b0, 8'd0});
                check("rd_j0", {log_wren[260], log_addr[260]}, {1'b0, 8'd1});
                check("wr_j0", {log_wren[263], log_addr[263], log_wd[263]}, {1'b1, 8'd1, 8'd0});
                check("wr_i0", {log_wren[264], log_addr[264], log_wd[264]}, {1'b1, 8'd0, 8'd1});
                check("rd_i1", {log_wren[265], log_addr[265]}, {1'b0, 8'd1});
            end
            repeat (3) @(negedge clk);
        end

        // Back-to-back: second start in the done cycle of the first run
        model_run({16'h0, 24'h13579B}, 3, 1'b1);
        launch(24'h13579B, 1'b1);
        wait_done(cyc, wr);
        $display("run key=13579b init=1 done_cycle=%0d writes=%0d", cyc, wr);
        check("b2b_first_done", cyc, 2305);
        model_run({16'h0, 24'h4B6579}, 3, 1'b0);
        launch(24'h4B6579, 1'b0);
        wait_done(cyc, wr);
        $display("run key=4b6579 init=0 done_cycle=%0d writes=%0d", cyc, wr);
        check("b2b_second_gap", cyc, 2049);
        check_s("b2b_sbox");
        repeat (3) @(negedge clk);

        // start held high mid-run is ignored
        model_run({16'h0, 24'hC0FFEE}, 3, 1'b1);
        launch(24'hC0FFEE, 1'b1);
        fork
            wait_done(cyc, wr);
            begin
                repeat (500) @(negedge clk);
                start = 1'b1; key = 24'hFFFFFF; do_init = 1'b0;
                repeat (100) @(negedge clk);
                start = 1'b0;
            end
        join
        $display("run key=c0ffee init=1 held_start done_cycle=%0d writes=%0d", cyc, wr);
        check("held_done_cycle", cyc, 2305);
        check_s("held_sbox");
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("held_extra_done", cnt, 0);

        // Asynchronous reset during the KSA
        launch(24'h0A0B0C, 1'b1);
        repeat (1000) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_outputs", {wren, busy, done, addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_idle_busy", busy, 0);
        check("arst_idle_wren", wren, 0);
        model_run({16'h0, 24'h0A0B0C}, 3, 1'b1);
        launch(24'h0A0B0C, 1'b1);
        wait_done(cyc, wr);
        $display("run key=0a0b0c init=1 after_reset done_cycle=%0d writes=%0d", cyc, wr);
        check("arst_done_cycle", cyc, 2305);
        check_s("arst_sbox");
        repeat (3) @(negedge clk);

        // KEY_BYTES=5, RD_LAT=3 instance, random key
        key5 = {$urandom, 8'($urandom)};
        model_run(key5, 5, 1'b1);
        start5 = 1'b1; do_init5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        cyc = 1; wr = 0; cnt = 0;
        while (!done5 && cyc < 6000) begin
            if (cyc < 4096) begin
                log_wren[cyc] = wren5;
                log_addr[cyc] = addr5;
            end
            if (wren5) wr++;
            @(negedge clk);
            cyc++;
        end
        $display("run5 key=%h init=1 done_cycle=%0d writes=%0d", key5, cyc, wr);
        check("k5_done_seen", done5, 1);
        check("k5_done_cycle", cyc, 256 + 2560 + 1);
        check("k5_writes", wr, 768);
        check("k5_wr_j0", log_wren[265], 1);
        check("k5_gap", log_wren[274], 0);
        check("k5_wr_j1", log_wren[275], 1);
        for (int x = 0; x < 256; x++) if (mem5[x] !== model_s[x]) cnt++;
        check("k5_sbox", cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
